fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the combinational control decoder. It holds the PC, issues one request at a time to instruction memory over a req/gnt/rvalid handshake, and presents the fetched word with its PC to decode over a valid/ready handshake. Execute-stage redirects (taken branch, JAL, JALR) load a new PC and squash any stale fetch, whether it is in flight or held.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0013, value driven on instr while nothing is valid (addi x0,x0,0).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; word aligned, bits[1:0] always 0.
imem_gnt  input  1  memory accepted the request this cycle.
imem_rvalid  input  1  read data valid, one cycle per granted request, 1 or more cycles after gnt.
imem_rdata  input  32  read data.
instr  output  32  instruction to decoder.
instr_pc  output  32  PC of instr.
instr_valid  output  1  instr/instr_pc valid.
instr_ready  input  1  decoder consumes instr this cycle.
redirect  input  1  load redirect_pc (from execute).
redirect_pc  input  32  new PC; bits[1:0] ignored and treated as 0.

Behaviour:
- Reset (async assert, rst_n=0):
  - pc=RESET_PC, state=FETCH, drop=0.
  - imem_req=0, instr_valid=0, instr=NOP_INSTR, instr_pc=RESET_PC.
  - imem_req is gated to 0 while rst_n=0. It rises in the first cycle after deassertion.
- At most one outstanding memory request. Registered state and flags.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt -> WAIT. Otherwise stay.
  - imem_addr changes only on a redirect.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with drop=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1 -> HOLD.
  - On imem_rvalid with drop=1: discard the data, clear drop -> FETCH.
- HOLD:
  - instr_valid=1. instr and instr_pc are stable until consumed.
  - On instr_ready: instr_valid<=0, instr<=NOP_INSTR, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) -> FETCH.
- Redirect has the highest priority and applies in any state. In every case pc<=redirect_pc&~3.
  - FETCH, no gnt: stay FETCH. The next cycle requests the new PC.
  - FETCH with gnt in the same cycle: -> WAIT with drop=1 (the granted word is stale).
  - WAIT without rvalid: drop<=1, stay WAIT.
  - WAIT with rvalid in the same cycle: discard the data -> FETCH, drop=0.
  - HOLD, including when instr_ready is asserted the same cycle:
    - instr_valid<=0, instr<=NOP_INSTR -> FETCH.
    - pc+4 is not applied.
    - The decoder's consumption that cycle is the responsibility of the flushing stage.
  - Back-to-back redirects: the last one wins. drop stays set until the one outstanding response returns.
- Latency:
  - gnt in cycle N, rvalid in N+1 -> instr_valid in N+2.
  - With instr_ready=1 in N+2, the next imem_req is in N+3. Best-case throughput is 1 instruction per 3 cycles.
- Reset asserted mid-operation: the state is abandoned immediately. A late rvalid arriving after reset release while in FETCH is ignored, because rvalid is only sampled in WAIT.
- Spurious imem_rvalid in FETCH or HOLD: ignored.

Test Plan:
- Reset release, memory with 1-cycle gnt and rvalid one cycle later, instr_ready=1 -> imem_addr sequence 0,4,8; instr_valid pulses carry instr_pc 0,4,8 with matching rdata; one instruction every 3 cycles.
- instr_ready held 0 for 5 cycles in HOLD -> instr/instr_pc stable, instr_valid=1, no imem_req; on ready, the next request is to pc+4.
- Redirect to 32'h0000_0103 while in WAIT, rvalid 3 cycles later -> that response is discarded, instr_valid stays 0, next imem_addr=32'h0000_0100, instr_pc of the next valid word=32'h100.
- Redirect in the same cycle as imem_gnt, and separately in the same cycle as rvalid -> both stale words are dropped; exactly one request to the redirect PC follows.
- Redirect in HOLD with instr_ready=1 the same cycle -> instr_valid falls next cycle, instr=32'h0000_0013, no pc+4; fetch from the redirect PC.
- PC=32'hFFFF_FFFC consumed -> next imem_addr=0. rst_n asserted during WAIT -> imem_req=0, instr_valid=0 immediately; after release the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage with redirect and squash
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);
   typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d;
   logic        drop_q, drop_d, valid_q, valid_d;
   logic [31:0] redirect_pc_w;
   assign redirect_pc_w = {redirect_pc[31:2], 2'b00};
   assign imem_req      = (state_q == FETCH) && rst_n;
   assign imem_addr     = pc_q;
   assign instr         = instr_q;
   assign instr_pc      = instr_pc_q;
   assign instr_valid   = valid_q;
   // next state: redirect overrides everything, drop marks the one stale response
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      valid_d    = valid_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      case (state_q)
         FETCH: begin
            if (redirect) pc_d = redirect_pc_w;
            if (imem_gnt) begin
               state_d = WAIT;
               drop_d  = redirect;
            end
         end
         WAIT: begin
            if (redirect) pc_d = redirect_pc_w;
            if (imem_rvalid) begin
               drop_d = 1'b0;
               if (redirect || drop_q) state_d = FETCH;
               else begin
                  state_d    = HOLD;
                  valid_d    = 1'b1;
                  instr_d    = imem_rdata;
                  instr_pc_d = pc_q;
               end
            end else if (redirect) drop_d = 1'b1;
         end
         HOLD: begin
            if (redirect || instr_ready) begin
               state_d = FETCH;
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               pc_d    = redirect ? redirect_pc_w : pc_q + 32'd4;
            end
         end
         default: state_d = FETCH;
      endcase
   end
   // state registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         instr_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
   logic        clk, rst_n;
   logic        imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, redirect;
   logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
   int          total = 0, bad = 0;
   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a);
      chk("issue_req", {31'd0, imem_req}, 32'd1);
      chk("issue_addr", imem_addr, a);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      chk("wait_req", {31'd0, imem_req}, 32'd0);
   endtask

   task automatic respond(input logic [31:0] d);
      imem_rvalid = 1'b1;
      imem_rdata  = d;
      step();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
   endtask

   task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
      issue(a);
      respond(d);
      chk("valid", {31'd0, instr_valid}, 32'd1);
      chk("instr", instr, d);
      chk("instr_pc", instr_pc, a);
      step();
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", imem_addr, a + 32'd4);
      chk("cleared_valid", {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
      step(); step();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, NOP);
      chk("rst_ipc", instr_pc, 32'h0);
      rst_n = 1'b1;
      #1;
      // sequential fetch, one instruction every three cycles
      fetch_one(32'h0, 32'hAAAA_0000);
      fetch_one(32'h4, 32'hAAAA_0004);
      fetch_one(32'h8, 32'hAAAA_0008);
      // decoder stall in HOLD, spurious rvalid ignored
      instr_ready = 1'b0;
      issue(32'hC);
      respond(32'hBBBB_000C);
      for (int i = 0; i < 5; i++) begin
         imem_rvalid = (i < 2);
         imem_rdata  = 32'hDEAD_BEEF;
         step();
         chk("hold_valid", {31'd0, instr_valid}, 32'd1);
         chk("hold_instr", instr, 32'hBBBB_000C);
         chk("hold_ipc", instr_pc, 32'hC);
         chk("hold_req", {31'd0, imem_req}, 32'd0);
      end
      imem_rvalid = 1'b0;
      instr_ready = 1'b1;
      step();
      chk("stall_release_req", {31'd0, imem_req}, 32'd1);
      chk("stall_release_addr", imem_addr, 32'h10);
      chk("stall_release_instr", instr, NOP);
      // redirect in WAIT, late response discarded
      issue(32'h10);
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      step();
      redirect = 1'b0;
      chk("rw_req", {31'd0, imem_req}, 32'd0);
      step(); step();
      respond(32'hDEAD_0010);
      chk("rw_valid", {31'd0, instr_valid}, 32'd0);
      chk("rw_req2", {31'd0, imem_req}, 32'd1);
      chk("rw_addr", imem_addr, 32'h100);
      fetch_one(32'h100, 32'hCCCC_0100);
      // redirect together with gnt
      chk("rg_addr0", imem_addr, 32'h104);
      imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
      step();
      imem_gnt = 1'b0; redirect = 1'b0;
      chk("rg_req", {31'd0, imem_req}, 32'd0);
      respond(32'hDEAD_0104);
      chk("rg_valid", {31'd0, instr_valid}, 32'd0);
      chk("rg_addr", imem_addr, 32'h200);
      fetch_one(32'h200, 32'hCCCC_0200);
      // redirect together with rvalid
      issue(32'h204);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0204; redirect = 1'b1; redirect_pc = 32'h300;
      step();
      imem_rvalid = 1'b0; redirect = 1'b0;
      chk("rr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rr_req", {31'd0, imem_req}, 32'd1);
      chk("rr_addr", imem_addr, 32'h300);
      fetch_one(32'h300, 32'hCCCC_0300);
      // redirect in HOLD with ready in the same cycle
      instr_ready = 1'b0;
      issue(32'h304);
      respond(32'hCCCC_0304);
      chk("rh_valid0", {31'd0, instr_valid}, 32'd1);
      instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
      step();
      redirect = 1'b0;
      chk("rh_valid", {31'd0, instr_valid}, 32'd0);
      chk("rh_instr", instr, NOP);
      chk("rh_req", {31'd0, imem_req}, 32'd1);
      chk("rh_addr", imem_addr, 32'h400);
      fetch_one(32'h400, 32'hCCCC_0400);
      // redirect in FETCH without gnt, then PC wrap
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      step();
      redirect = 1'b0;
      chk("rf_addr", imem_addr, 32'hFFFF_FFFC);
      issue(32'hFFFF_FFFC);
      respond(32'hEEEE_FFFC);
      chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
      step();
      chk("wrap_addr", imem_addr, 32'h0);
      fetch_one(32'h0, 32'hEEEE_0000);
      // reset during WAIT, late rvalid after release ignored
      issue(32'h4);
      rst_n = 1'b0;
      #1;
      chk("mr_req", {31'd0, imem_req}, 32'd0);
      chk("mr_valid", {31'd0, instr_valid}, 32'd0);
      chk("mr_instr", instr, NOP);
      step();
      rst_n = 1'b1;
      #1;
      chk("mr_rel_req", {31'd0, imem_req}, 32'd1);
      chk("mr_rel_addr", imem_addr, 32'h0);
      respond(32'hDEAD_0004);
      chk("late_valid", {31'd0, instr_valid}, 32'd0);
      chk("late_addr", imem_addr, 32'h0);
      fetch_one(32'h0, 32'hFFFF_0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
